// File: rtl/rr_priority_arbiter.sv
// +-----------------------------------------------------------------------------
// | rr_priority_arbiter: N-requester arbiter with run-time round-robin or fixed
// | priority, registered one-hot/encoded grant, done/abort/hold-timeout release.
// | Revision: 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

module rr_priority_arbiter #(
  parameter  int N_REQ    = 4,
  parameter  int MAX_HOLD = 16,
  localparam int IDX_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  localparam int HOLD_W   = $clog2(MAX_HOLD + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fixed_prio,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid,
  output logic             timeout
);

  // MAX_HOLD=0 would give a zero-width counter; keep at least one bit.
  localparam int                CNT_W   = (HOLD_W > 0) ? HOLD_W : 1;
  localparam logic [CNT_W-1:0]  MAX_CNT = CNT_W'(MAX_HOLD);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [N_REQ-1:0] grant_nxt;
  logic [IDX_W-1:0] idx_nxt;
  logic [IDX_W-1:0] ptr, ptr_nxt;
  logic [IDX_W-1:0] win_idx;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             mode_fixed, mode_nxt;
  logic             timeout_nxt;
  logic             hold_expired;
  logic             release_now;

  // Modulo-N_REQ addition; N_REQ need not be a power of two.
  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                input int unsigned     off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= 32'(N_REQ)) s = s - 32'(N_REQ);
    return IDX_W'(s);
  endfunction

  // Winner selection: later loop iterations override, so the iteration order
  // encodes the priority (highest index for fixed, nearest to ptr for RR).
  always_comb begin
    win_idx = '0;
    if (fixed_prio) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (req[i]) win_idx = IDX_W'(i);
      end
    end else begin
      for (int k = N_REQ - 1; k >= 0; k--) begin
        if (req[wrap_add(ptr, 32'(k))]) win_idx = wrap_add(ptr, 32'(k));
      end
    end
  end

  assign hold_expired = (MAX_HOLD != 0) && (cnt == MAX_CNT);
  assign release_now  = done || !req[grant_idx] || hold_expired;

  always_comb begin
    state_nxt   = state;
    grant_nxt   = grant;
    idx_nxt     = grant_idx;
    ptr_nxt     = ptr;
    cnt_nxt     = cnt;
    mode_nxt    = mode_fixed;
    timeout_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          state_nxt          = GRANT;
          grant_nxt          = '0;
          grant_nxt[win_idx] = 1'b1;
          idx_nxt            = win_idx;
          cnt_nxt            = CNT_W'(1);
          mode_nxt           = fixed_prio;
        end
      end
      GRANT: begin
        if (release_now) begin
          state_nxt   = IDLE;
          grant_nxt   = '0;
          timeout_nxt = !done && req[grant_idx];
          if (!mode_fixed) ptr_nxt = wrap_add(grant_idx, 32'd1);
        end else if ((MAX_HOLD != 0) && (cnt != MAX_CNT)) begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      grant      <= '0;
      grant_idx  <= '0;
      ptr        <= '0;
      cnt        <= '0;
      mode_fixed <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      grant_idx  <= idx_nxt;
      ptr        <= ptr_nxt;
      cnt        <= cnt_nxt;
      mode_fixed <= mode_nxt;
      timeout    <= timeout_nxt;
    end
  end

  assign grant_valid = |grant;

`ifndef SYNTHESIS
  a_onehot:    assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant));
  a_valid:     assert property (@(posedge clk) disable iff (!rst_n) grant_valid == (|grant));
  a_idx_hit:   assert property (@(posedge clk) disable iff (!rst_n) grant_valid |-> grant[grant_idx]);
  a_idx_range: assert property (@(posedge clk) disable iff (!rst_n) 32'(grant_idx) < 32'(N_REQ));
`endif

endmodule

`default_nettype wire

// File: tb/tb_rr_priority_arbiter.sv
// Scoreboard bench: a 4-requester instance (hold limit 4) and a 5-requester
// instance (timeout disabled) run in lockstep against a behavioural model.
`default_nettype none

module tb_rr_priority_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       fp_a, done_a, gv_a, to_a;
  logic [3:0] req_a, grant_a;
  logic [1:0] idx_a;
  logic       fp_b, done_b, gv_b, to_b;
  logic [4:0] req_b, grant_b;
  logic [2:0] idx_b;

  rr_priority_arbiter #(.N_REQ(4), .MAX_HOLD(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .fixed_prio(fp_a), .req(req_a), .done(done_a),
    .grant(grant_a), .grant_idx(idx_a), .grant_valid(gv_a), .timeout(to_a)
  );

  rr_priority_arbiter #(.N_REQ(5), .MAX_HOLD(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .fixed_prio(fp_b), .req(req_b), .done(done_b),
    .grant(grant_b), .grant_idx(idx_b), .grant_valid(gv_b), .timeout(to_b)
  );

  typedef struct {
    logic busy;
    int   idx;
    int   ptr;
    int   cnt;
    logic fixed;
    logic to;
  } m_t;

  typedef struct {
    logic [7:0] g;
    int         idx;
    logic       v;
    logic       to;
  } e_t;

  m_t ma, mb;
  e_t qa[$], qb[$];
  int n_tests = 0;
  int n_fail  = 0;

  function automatic m_t reset_model();
    m_t r;
    r.busy = 1'b0; r.idx = 0; r.ptr = 0; r.cnt = 0; r.fixed = 1'b0; r.to = 1'b0;
    return r;
  endfunction

  function automatic m_t mstep(input m_t m, input int n, input int maxh,
                               input logic fp, input logic [7:0] rq, input logic dn);
    m_t   r;
    int   w;
    bit   found;
    logic rel;
    r     = m;
    r.to  = 1'b0;
    found = 1'b0;
    w     = 0;
    if (!m.busy) begin
      if (fp) begin
        for (int i = n - 1; i >= 0; i--)
          if (!found && rq[i]) begin found = 1'b1; w = i; end
      end else begin
        for (int k = 0; k < n; k++)
          if (!found && rq[(m.ptr + k) % n]) begin found = 1'b1; w = (m.ptr + k) % n; end
      end
      if (found) begin
        r.busy = 1'b1; r.idx = w; r.cnt = 1; r.fixed = fp;
      end
    end else begin
      rel = 1'b1;
      if (dn) r.to = 1'b0;
      else if (!rq[m.idx]) r.to = 1'b0;
      else if (maxh != 0 && m.cnt == maxh) r.to = 1'b1;
      else begin
        rel = 1'b0;
        if (maxh != 0) r.cnt = m.cnt + 1;
      end
      if (rel) begin
        r.busy = 1'b0;
        if (!m.fixed) r.ptr = (m.idx + 1) % n;
      end
    end
    return r;
  endfunction

  function automatic e_t expect_of(input m_t m);
    e_t e;
    e.g   = m.busy ? 8'(1 << m.idx) : 8'd0;
    e.idx = m.idx;
    e.v   = m.busy;
    e.to  = m.to;
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step(input string tag);
    e_t ea, eb;
    ma = mstep(ma, 4, 4, fp_a, {4'b0, req_a}, done_a);
    qa.push_back(expect_of(ma));
    mb = mstep(mb, 5, 0, fp_b, {3'b0, req_b}, done_b);
    qb.push_back(expect_of(mb));
    @(posedge clk);
    #1;
    ea = qa.pop_front();
    eb = qb.pop_front();
    check({tag, " a.grant"}, 32'(grant_a), 32'(ea.g));
    check({tag, " a.valid"}, 32'(gv_a), 32'(ea.v));
    check({tag, " a.timeout"}, 32'(to_a), 32'(ea.to));
    if (ea.v) check({tag, " a.idx"}, 32'(idx_a), 32'(ea.idx));
    check({tag, " b.grant"}, 32'(grant_b), 32'(eb.g));
    check({tag, " b.valid"}, 32'(gv_b), 32'(eb.v));
    check({tag, " b.timeout"}, 32'(to_b), 32'(eb.to));
    if (eb.v) check({tag, " b.idx"}, 32'(idx_b), 32'(eb.idx));
  endtask

  task automatic do_reset(input string tag);
    done_a = 1'b0;
    done_b = 1'b0;
    rst_n  = 1'b0;
    #1;
    check({tag, " a.grant"}, 32'(grant_a), 32'd0);
    check({tag, " a.valid"}, 32'(gv_a), 32'd0);
    check({tag, " a.timeout"}, 32'(to_a), 32'd0);
    check({tag, " b.grant"}, 32'(grant_b), 32'd0);
    check({tag, " b.valid"}, 32'(gv_b), 32'd0);
    ma = reset_model();
    mb = reset_model();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int exp_rr[5];
    int j;
    exp_rr = '{0, 1, 2, 3, 0};
    rst_n  = 1'b1;
    fp_a = 1'b0; done_a = 1'b0; req_a = '0;
    fp_b = 1'b0; done_b = 1'b0; req_b = '0;
    #2;

    do_reset("reset");
    for (int i = 0; i < 5; i++) step("idle");

    // Round-robin rotation with done on each first grant cycle.
    req_a = 4'b1111;
    j = 0;
    for (int i = 0; i < 10; i++) begin
      done_a = ma.busy;
      if (ma.busy && j < 5) begin
        check("rr.seq", 32'(idx_a), 32'(exp_rr[j]));
        j++;
      end
      step("rr");
    end
    done_a = 1'b0; req_a = '0;

    // Fixed priority, then back to round-robin with the pointer untouched.
    do_reset("reset2");
    fp_a = 1'b1; req_a = 4'b1011;
    for (int i = 0; i < 6; i++) begin
      done_a = ma.busy;
      if (ma.busy) check("fixed.seq", 32'(idx_a), 32'd3);
      step("fixed");
    end
    fp_a = 1'b0; done_a = 1'b0;
    step("rr_after_fixed");
    check("rr_after_fixed.idx", 32'(idx_a), 32'd0);
    done_a = 1'b1;
    step("rr_after_fixed_rel");
    done_a = 1'b0; req_a = '0;
    step("drain");

    // Hold timeout on A; long hold without timeout on B (limit disabled).
    do_reset("reset3");
    req_a = 4'b0100;
    req_b = 5'b10000;
    for (int i = 0; i < 14; i++) step("timeout");
    check("hold_b.idx", 32'(idx_b), 32'd4);
    for (int i = 0; i < 10; i++) step("hold_b");
    req_a = '0;

    // Abort release on B, then wrap from index 4 back to 0.
    req_b = 5'b00000;
    step("abort");
    req_b = 5'b10001;
    step("wrap");
    check("wrap.idx", 32'(idx_b), 32'd0);
    done_b = 1'b1;
    step("wrap_rel");
    done_b = 1'b0; req_b = '0;
    step("drain2");

    // Asynchronous reset in the middle of a grant.
    req_a = 4'b0100;
    step("pre_async");
    step("pre_async");
    check("pre_async.idx", 32'(idx_a), 32'd2);
    do_reset("async");
    req_a = 4'b1111;
    step("post_async");
    check("post_async.idx", 32'(idx_a), 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 3) == 0) req_a = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) req_b = 5'($urandom_range(0, 31));
      fp_a   = ($urandom_range(0, 1) == 1);
      fp_b   = ($urandom_range(0, 1) == 1);
      done_a = ($urandom_range(0, 3) == 0);
      done_b = ($urandom_range(0, 3) == 0);
      step("random");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
